// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the IF (fetch) and MEM (load/store) stages.
// Optional stall-cycle performance counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_wen,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic                  dm_stall,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_ready
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_if_stall,
    output logic [31:0]           perf_dm_stall
`endif
);

    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM, DONE} state_t;

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_t                  state_q, state_d;
    logic                    mem_cs_q, mem_cs_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
    logic                    if_ack_q, if_ack_d;
    logic                    dm_ack_q, dm_ack_d;
    logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;

    logic grant_dm;
    logic grant_if;
    logic dm_side;

    // Data wins a tie until fetch has been kept waiting STARVE_LIMIT cycles.
    assign grant_dm = (state_q == IDLE) && dm_req && (!if_req || (starve_cnt_q < STARVE_MAX));
    assign grant_if = (state_q == IDLE) && if_req && !grant_dm;
    // dm_ack_q is high in DONE exactly when the finished access was a data access.
    assign dm_side  = (state_q == ACC_DM) || ((state_q == DONE) && dm_ack_q);

    always_comb begin
        // NOTE: every signal gets its default first, so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        mem_cs_d     = mem_cs_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d    = ACC_DM;
                    mem_cs_d   = 1'b1;
                    mem_we_d   = dm_wen;
                    mem_addr_d = dm_addr;
                    mem_din_d  = dm_wdata;
                end else if (grant_if) begin
                    state_d    = ACC_IF;
                    mem_cs_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            ACC_IF: begin
                if (mem_ready) begin
                    state_d    = DONE;
                    mem_cs_d   = 1'b0;
                    if_rdata_d = mem_dout;
                    if_ack_d   = 1'b1;
                end
            end
            ACC_DM: begin
                if (mem_ready) begin
                    state_d  = DONE;
                    mem_cs_d = 1'b0;
                    mem_we_d = 1'b0;
                    dm_ack_d = 1'b1;
                    if (!mem_we_q) dm_rdata_d = mem_dout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!if_req || grant_if) begin
            starve_cnt_d = '0;
        end else if (dm_side && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_ack   = if_ack_q;
    assign dm_ack   = dm_ack_q;
    assign if_stall = if_req & ~if_ack_q;
    assign dm_stall = dm_req & ~dm_ack_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_dm_stall_q, perf_dm_stall_d;

    always_comb begin
        perf_if_stall_d = perf_if_stall_q;
        perf_dm_stall_d = perf_dm_stall_q;
        if (if_stall && (perf_if_stall_q != 32'hFFFF_FFFF)) perf_if_stall_d = perf_if_stall_q + 32'd1;
        if (dm_stall && (perf_dm_stall_q != 32'hFFFF_FFFF)) perf_dm_stall_d = perf_dm_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall_q <= '0;
            perf_dm_stall_q <= '0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_dm_stall_q <= perf_dm_stall_d;
        end
    end

    assign perf_if_stall = perf_if_stall_q;
    assign perf_dm_stall = perf_dm_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences, and random traffic
// checked against a transaction-level schedule model. Define ARB_PERF_CNT_EN to also check counters.
module tb_mem_port_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack, if_stall;
    logic        dm_req = 1'b0;
    logic        dm_wen = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack, dm_stall;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_ready;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall, perf_dm_stall;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(SL)) dut (
`ifdef ARB_PERF_CNT_EN
        .perf_if_stall (perf_if_stall),
        .perf_dm_stall (perf_dm_stall),
`endif
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_wen    (dm_wen),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .dm_stall  (dm_stall),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    // Memory responder: mem_ready after wait_cfg extra cycles of mem_cs; contents reload on rst.
    logic [31:0] mem_arr [256];
    int unsigned wait_cfg = 0;
    int unsigned wait_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            wait_cnt <= 0;
        end else begin
            if (!mem_cs || mem_ready) wait_cnt <= 0;
            else                      wait_cnt <= wait_cnt + 1;
            if (mem_cs && mem_we && mem_ready) mem_arr[mem_addr[9:2]] <= mem_din;
        end
    end

    assign mem_ready = mem_cs && (wait_cnt == wait_cfg);
    assign mem_dout  = mem_arr[mem_addr[9:2]];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_wen = 1'b0; wait_cfg = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_wen;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        e_cs;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_if_ack;
        logic        e_dm_ack;
        logic        e_if_stall;
        logic        e_dm_stall;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd, input logic cs,
                                input logic we, input logic [31:0] ea, input logic ika, input logic dka,
                                input logic ist, input logic dst, input logic [31:0] rd);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_wen = dw; v.dm_addr = da; v.dm_wdata = dd;
        v.e_cs = cs; v.e_we = we; v.e_addr = ea; v.e_if_ack = ika; v.e_dm_ack = dka;
        v.e_if_stall = ist; v.e_dm_stall = dst; v.e_rdata = rd;
        return v;
    endfunction

    // Random-phase model state: each access is a scheduled window on the cycle axis.
    logic [31:0] ref_mem [256];
    int          next_free, win_lo, win_hi, ack_at, starve, g;
    logic        owner_dm, acc_we, in_dm_win;
    logic [31:0] acc_addr, acc_din, acc_rdata, e_if_rdata, e_dm_rdata, if_a, dm_a, dm_d;
    logic        if_pend, dm_pend, dm_w, e_cs, e_if_ack, e_dm_ack;

    // Directed-sequence bookkeeping.
    int          acks, if_cnt, dm_cnt, exp_if_st, exp_dm_st, slot;
    logic        ea_if, ea_dm;

    initial begin
        // ---- reset state
        do_reset();
        #1;
        check("rst_mem_cs",   32'(mem_cs),   32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_if_ack",   32'(if_ack),   32'd0);
        check("rst_dm_ack",   32'(dm_ack),   32'd0);
        check("rst_mem_addr", mem_addr,      32'd0);
        check("rst_mem_din",  mem_din,       32'd0);
        check("rst_if_rdata", if_rdata,      32'd0);
        check("rst_dm_rdata", dm_rdata,      32'd0);

        // ---- table: single zero-wait load, then three back-to-back fetches
        vecs.push_back(mk(0, 0,     1, 0, 32'h10, 0, 0, 0, 0,      0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,     1, 0, 32'h10, 0, 1, 0, 32'h10, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0,      0, 0, 0, 0,      0, 1, 0, 0, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 0,     0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0,      0, 1, 0, 32'h0,  0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0,      0, 0, 0, 0,      1, 0, 0, 0, init_word(0)));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0,      0, 0, 0, 0,      0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0,      0, 1, 0, 32'h4,  0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0,      0, 0, 0, 0,      1, 0, 0, 0, init_word(1)));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0,      0, 0, 0, 0,      0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0,      0, 1, 0, 32'h8,  0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0,      0, 0, 0, 0,      1, 0, 0, 0, init_word(2)));
        vecs.push_back(mk(0, 0,     0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req; dm_wen = vecs[i].dm_wen;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            #1;
            check($sformatf("vec%0d_mem_cs", i),   32'(mem_cs),   32'(vecs[i].e_cs));
            if (vecs[i].e_cs) begin
                check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
                check($sformatf("vec%0d_mem_we", i),   32'(mem_we), 32'(vecs[i].e_we));
            end
            check($sformatf("vec%0d_if_ack", i),   32'(if_ack),   32'(vecs[i].e_if_ack));
            check($sformatf("vec%0d_dm_ack", i),   32'(dm_ack),   32'(vecs[i].e_dm_ack));
            check($sformatf("vec%0d_if_stall", i), 32'(if_stall), 32'(vecs[i].e_if_stall));
            check($sformatf("vec%0d_dm_stall", i), 32'(dm_stall), 32'(vecs[i].e_dm_stall));
            if (vecs[i].e_if_ack) check($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
            if (vecs[i].e_dm_ack) check($sformatf("vec%0d_dm_rdata", i), dm_rdata, vecs[i].e_rdata);
            tick();
        end

        // ---- store with two wait cycles: mem_din held 3 cycles, one ack, dm_rdata untouched
        wait_cfg = 2;
        acks = 0;
        for (int c = 0; c < 7; c++) begin
            dm_req = (c < 4); dm_wen = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h1234_5678;
            #1;
            check("st_mem_cs", 32'(mem_cs), 32'((c >= 1) && (c <= 3)));
            if ((c >= 1) && (c <= 3)) begin
                check("st_mem_we",   32'(mem_we), 32'd1);
                check("st_mem_din",  mem_din,     32'h1234_5678);
                check("st_mem_addr", mem_addr,    32'h20);
            end
            check("st_dm_ack", 32'(dm_ack), 32'(c == 4));
            check("st_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
            if (dm_ack) acks++;
            tick();
        end
        check("st_ack_count", 32'(acks), 32'd1);
        check("st_mem_word", mem_arr[8], 32'h1234_5678);
        wait_cfg = 0;

        // ---- both ports requesting, zero wait: DM, DM, IF repeating, acks every 3 cycles from cycle 2
        do_reset();
        if_cnt = 0; dm_cnt = 0; exp_if_st = 0; exp_dm_st = 0;
        for (int c = 0; c < 20; c++) begin
            slot  = (c - 2) / 3;
            ea_if = (c >= 2) && (((c - 2) % 3) == 0) && ((slot % 3) == 2);
            ea_dm = (c >= 2) && (((c - 2) % 3) == 0) && ((slot % 3) != 2);
            if (ea_if) if_cnt++;
            if (ea_dm) dm_cnt++;
            if_req = 1'b1; dm_req = 1'b1; dm_wen = 1'b0;
            if_addr = 32'h100 + 32'(if_cnt * 4);
            dm_addr = 32'h200 + 32'(dm_cnt * 4);
            #1;
            check($sformatf("starve_if_ack_c%0d", c), 32'(if_ack), 32'(ea_if));
            check($sformatf("starve_dm_ack_c%0d", c), 32'(dm_ack), 32'(ea_dm));
            if (!ea_if) exp_if_st++;
            if (!ea_dm) exp_dm_st++;
            tick();
        end
`ifdef ARB_PERF_CNT_EN
        check("perf_if_stall", perf_if_stall, 32'(exp_if_st));
        check("perf_dm_stall", perf_dm_stall, 32'(exp_dm_st));
`endif

        // ---- reset during a waiting fetch abandons it
        do_reset();
        wait_cfg = 5;
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        check("rst_mid_c0_cs", 32'(mem_cs), 32'd0);
        tick();
        #1;
        check("rst_mid_c1_cs", 32'(mem_cs), 32'd1);
        tick();
        #1;
        check("rst_mid_c2_cs", 32'(mem_cs), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; if_req = 1'b0;
        #1;
        check("rst_mid_c3_cs",  32'(mem_cs), 32'd0);
        check("rst_mid_c3_ack", 32'(if_ack), 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            #1;
            check("rst_mid_no_ack", 32'(if_ack), 32'd0);
            check("rst_mid_no_cs",  32'(mem_cs), 32'd0);
        end
        wait_cfg = 0;

        // ---- random traffic against the schedule model
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        next_free = 0; win_lo = -10; win_hi = -10; ack_at = -10; starve = 0;
        owner_dm = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_din = '0; acc_rdata = '0;
        if_pend = 1'b0; dm_pend = 1'b0; if_a = '0; dm_a = '0; dm_d = '0; dm_w = 1'b0;
        e_if_rdata = '0; e_dm_rdata = '0;
        for (int k = 0; k < 1500; k++) begin
            e_cs     = (k >= win_lo) && (k <= win_hi);
            e_if_ack = (k == ack_at) && !owner_dm;
            e_dm_ack = (k == ack_at) && owner_dm;
            if (e_if_ack) begin
                if_pend = 1'b0;
                e_if_rdata = acc_rdata;
            end
            if (e_dm_ack) begin
                dm_pend = 1'b0;
                if (!acc_we) e_dm_rdata = acc_rdata;
            end
            if (!if_pend && ($urandom_range(0, 1) != 0)) begin
                if_pend = 1'b1;
                if_a = rand_addr();
            end
            if (!dm_pend && ($urandom_range(0, 2) != 0)) begin
                dm_pend = 1'b1;
                dm_w = 1'($urandom_range(0, 1));
                dm_a = rand_addr();
                dm_d = $urandom();
            end
            if (k >= next_free) wait_cfg = $urandom_range(0, 2);
            if_req = if_pend; if_addr = if_a;
            dm_req = dm_pend; dm_wen = dm_w; dm_addr = dm_a; dm_wdata = dm_d;
            #1;
            check("rnd_mem_cs", 32'(mem_cs), 32'(e_cs));
            if (e_cs) begin
                check("rnd_mem_addr", mem_addr, acc_addr);
                check("rnd_mem_we", 32'(mem_we), 32'(acc_we));
                if (acc_we) check("rnd_mem_din", mem_din, acc_din);
            end
            check("rnd_if_ack",   32'(if_ack),   32'(e_if_ack));
            check("rnd_dm_ack",   32'(dm_ack),   32'(e_dm_ack));
            check("rnd_if_stall", 32'(if_stall), 32'(if_pend && !e_if_ack));
            check("rnd_dm_stall", 32'(dm_stall), 32'(dm_pend && !e_dm_ack));
            check("rnd_if_rdata", if_rdata, e_if_rdata);
            check("rnd_dm_rdata", dm_rdata, e_dm_rdata);

            // Fetch waits through data accesses (their wait cycles plus the ack cycle) count toward starvation.
            in_dm_win = owner_dm && (k >= win_lo) && (k <= ack_at);
            g = 0;
            if (k >= next_free) begin
                if (dm_pend && (!if_pend || (starve < SL))) g = 2;
                else if (if_pend)                          g = 1;
            end
            if (!if_pend || (g == 1))           starve = 0;
            else if (in_dm_win && (starve < SL)) starve = starve + 1;
            if (g != 0) begin
                owner_dm  = (g == 2);
                acc_addr  = (g == 2) ? dm_a : if_a;
                acc_we    = (g == 2) && dm_w;
                acc_din   = dm_d;
                win_lo    = k + 1;
                win_hi    = k + 1 + int'(wait_cfg);
                ack_at    = k + 2 + int'(wait_cfg);
                next_free = k + 3 + int'(wait_cfg);
                acc_rdata = ref_mem[acc_addr[9:2]];
                if (acc_we) ref_mem[acc_addr[9:2]] = dm_d;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
